// File: rtl/multicycle_alu.sv
// Registered ALU between the A/B operand registers and the Z (HI/LO) pair.
// Single-cycle ops finish in one clock; signed mul/div iterate WIDTH steps under start/busy/done.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 start,
  input  logic [4:0]           opcode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   C,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_hi;
  logic [WIDTH-1:0]  r_lo;
  logic [WIDTH-1:0]  r_b;
  logic              r_is_div;
  logic              r_qneg;
  logic              r_rneg;
  logic              r_dz;

  logic signed [WIDTH-1:0] w_a_s;
  logic signed [WIDTH-1:0] w_b_s;
  logic [SHW-1:0]          w_shamt;
  logic [2*WIDTH-1:0]      w_ror;
  logic [2*WIDTH-1:0]      w_rol;
  logic [WIDTH-1:0]        w_lo;
  logic                    w_keep;
  logic                    w_multi;
  logic [WIDTH:0]          w_msum;
  logic [WIDTH:0]          w_dshift;
  logic [WIDTH:0]          w_ddiff;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] fix_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] fix_2w(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign w_a_s   = A;
  assign w_b_s   = B;
  assign w_shamt = B[SHW-1:0];
  // Rotates fall out of shifting the operand concatenated with itself.
  assign w_ror   = {A, A} >> w_shamt;
  assign w_rol   = {A, A} << w_shamt;
  assign w_multi = (opcode == OP_MUL) || (opcode == OP_DIV);

  always_comb begin
    w_lo   = '0;
    w_keep = 1'b0;
    case (opcode)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: w_lo = A + B;
      OP_SUB:                                w_lo = A - B;
      OP_AND, OP_ANDI:                       w_lo = A & B;
      OP_OR, OP_ORI:                         w_lo = A | B;
      OP_NEG:                                w_lo = -B;
      OP_NOT:                                w_lo = ~B;
      OP_SHR:                                w_lo = A >> w_shamt;
      OP_SHL:                                w_lo = A << w_shamt;
      OP_ROR:                                w_lo = w_ror[WIDTH-1:0];
      OP_ROL:                                w_lo = w_rol[2*WIDTH-1:WIDTH];
      OP_BR, OP_NOP, OP_HALT:                w_keep = 1'b1;
      default:                               w_lo = '0;
    endcase
  end

  // Multiply: {HI,LO} shifts right, multiplier drains out of LO[0].
  // Divide: restoring step, dividend shifts out of LO[MSB], quotient bits shift in.
  assign w_msum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_dshift = {r_hi, r_lo[WIDTH-1]};
  assign w_ddiff  = w_dshift - {1'b0, r_b};

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state     <= IDLE;
      C           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            if (w_multi) begin
              busy     <= 1'b1;
              r_is_div <= (opcode == OP_DIV);
              r_cnt    <= CW'(WIDTH);
              r_lo     <= mag(w_a_s);
              r_b      <= mag(w_b_s);
              r_qneg   <= w_a_s[WIDTH-1] ^ w_b_s[WIDTH-1];
              r_rneg   <= w_a_s[WIDTH-1];
              if ((opcode == OP_DIV) && (B == '0)) begin
                r_dz    <= 1'b1;
                r_hi    <= A;
                r_state <= FIX;
              end else begin
                r_dz    <= 1'b0;
                r_hi    <= '0;
                r_state <= ITER;
              end
            end else begin
              done <= 1'b1;
              if (!w_keep) C <= {{WIDTH{1'b0}}, w_lo};
            end
          end
        end
        ITER: begin
          if (r_is_div) begin
            if (!w_ddiff[WIDTH]) begin
              r_hi <= w_ddiff[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], 1'b1};
            end else begin
              r_hi <= w_dshift[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_hi <= w_msum[WIDTH:1];
            r_lo <= {w_msum[0], r_lo[WIDTH-1:1]};
          end
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= FIX;
        end
        FIX: begin
          if (r_dz)
            C <= {r_hi, {WIDTH{1'b1}}};
          else if (r_is_div)
            C <= {fix_w(r_hi, r_rneg), fix_w(r_lo, r_qneg)};
          else
            C <= fix_2w({r_hi, r_lo}, r_qneg);
          done        <= 1'b1;
          busy        <= 1'b0;
          div_by_zero <= r_dz;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: a 32-bit vector table plus hand sequences,
// and an 8-bit instance for the overflow corners.
module tb_multicycle_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear, start, start8;
  logic [4:0]  opcode, opcode8;
  logic [31:0] A, B;
  logic [7:0]  A8, B8;
  logic [63:0] C;
  logic [15:0] C8;
  logic        busy, done, dz, busy8, done8, dz8;

  int n_vec = 0;
  int n_err = 0;

  multicycle_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .clear(clear), .start(start), .opcode(opcode), .A(A), .B(B),
    .C(C), .busy(busy), .done(done), .div_by_zero(dz)
  );

  multicycle_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .clear(clear), .start(start8), .opcode(opcode8), .A(A8), .B(B8),
    .C(C8), .busy(busy8), .done(done8), .div_by_zero(dz8)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] c;
    int          lat;
    int          bcyc;
    logic        dz;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic run32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] c, output int lat, output int bcyc,
                       output logic d, output logic dn_after);
    @(negedge clk);
    opcode = op; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; bcyc = 0;
    while (!done && lat < 200) begin
      if (busy) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy) bcyc++;
    c = C; d = dz;
    @(posedge clk); #1;
    dn_after = done;
  endtask

  task automatic run8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] c, output int lat);
    @(negedge clk);
    opcode8 = op; A8 = a; B8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    c = C8;
  endtask

  initial begin
    logic [63:0] c;
    logic [15:0] c8;
    int lat, bcyc, ndone, first_lat;
    logic d, dn_after;
    logic [63:0] first_c;

    tbl.push_back('{5'b00011, 32'h00000005, 32'hFFFFFFFE, 64'h00000000_00000003, 1, 0, 1'b0});
    tbl.push_back('{5'b00100, 32'h0000000A, 32'h00000003, 64'h00000000_00000007, 1, 0, 1'b0});
    tbl.push_back('{5'b00100, 32'h00000000, 32'h00000001, 64'h00000000_FFFFFFFF, 1, 0, 1'b0});
    tbl.push_back('{5'b01001, 32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_F000F000, 1, 0, 1'b0});
    tbl.push_back('{5'b01101, 32'hF0F0F0F0, 32'h0F000000, 64'h00000000_FFF0F0F0, 1, 0, 1'b0});
    tbl.push_back('{5'b10000, 32'h12345678, 32'h00000005, 64'h00000000_FFFFFFFB, 1, 0, 1'b0});
    tbl.push_back('{5'b10001, 32'h00000000, 32'h0000FFFF, 64'h00000000_FFFF0000, 1, 0, 1'b0});
    tbl.push_back('{5'b00101, 32'h80000000, 32'h0000001F, 64'h00000000_00000001, 1, 0, 1'b0});
    tbl.push_back('{5'b00110, 32'h00000001, 32'h00000024, 64'h00000000_00000010, 1, 0, 1'b0});
    tbl.push_back('{5'b01000, 32'h80000001, 32'h00000001, 64'h00000000_00000003, 1, 0, 1'b0});
    tbl.push_back('{5'b00111, 32'h00000001, 32'h00000021, 64'h00000000_80000000, 1, 0, 1'b0});
    tbl.push_back('{5'b11001, 32'hDEADBEEF, 32'h12345678, 64'h00000000_80000000, 1, 0, 1'b0});
    tbl.push_back('{5'b11111, 32'hDEADBEEF, 32'h12345678, 64'h00000000_00000000, 1, 0, 1'b0});
    tbl.push_back('{5'b01110, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 34, 33, 1'b0});
    tbl.push_back('{5'b01111, 32'hFFFFFFEF, 32'h00000005, 64'hFFFFFFFE_FFFFFFFD, 34, 33, 1'b0});
    tbl.push_back('{5'b01111, 32'h00000009, 32'h00000000, 64'h00000009_FFFFFFFF, 2, 1, 1'b1});
    tbl.push_back('{5'b00011, 32'h00000001, 32'h00000001, 64'h00000000_00000002, 1, 0, 1'b0});
    tbl.push_back('{5'b01110, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 34, 33, 1'b0});
    tbl.push_back('{5'b01111, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34, 33, 1'b0});
    tbl.push_back('{5'b01110, 32'h00003039, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFCFC7, 34, 33, 1'b0});
    tbl.push_back('{5'b01111, 32'h00000064, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 34, 33, 1'b0});
    tbl.push_back('{5'b00000, 32'h00001000, 32'h00000020, 64'h00000000_00001020, 1, 0, 1'b0});
    tbl.push_back('{5'b11010, 32'h00000000, 32'h00000000, 64'h00000000_00001020, 1, 0, 1'b0});

    clear = 1'b1; start = 1'b0; start8 = 1'b0;
    opcode = '0; A = '0; B = '0; opcode8 = '0; A8 = '0; B8 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_C", C, 64'h0);
    chk("rst_flags", {61'h0, busy, done, dz}, 64'h0);
    chk("rst8_C", {48'h0, C8}, 64'h0);
    chk("rst8_flags", {61'h0, busy8, done8, dz8}, 64'h0);
    @(negedge clk);
    clear = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      run32(tbl[i].op, tbl[i].a, tbl[i].b, c, lat, bcyc, d, dn_after);
      chk($sformatf("v%0d_C", i), c, tbl[i].c);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
      chk($sformatf("v%0d_busy_cycles", i), 64'(bcyc), 64'(tbl[i].bcyc));
      chk($sformatf("v%0d_div_by_zero", i), {63'h0, d}, {63'h0, tbl[i].dz});
      chk($sformatf("v%0d_done_pulse", i), {63'h0, dn_after}, 64'h0);
    end

    // Start during a multiply is ignored; operand changes after acceptance are harmless.
    @(negedge clk);
    opcode = 5'b01110; A = 32'hFFFFFFFD; B = 32'h00000007; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; first_lat = 0; first_c = '0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      if (done) begin
        ndone++;
        if (ndone == 1) begin first_lat = cyc; first_c = C; end
      end
      if (cyc == 4) begin
        opcode = 5'b00011; A = 32'h1; B = 32'h1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("ign_ndone", 64'(ndone), 64'd1);
    chk("ign_latency", 64'(first_lat), 64'd34);
    chk("ign_C", first_c, 64'hFFFFFFFF_FFFFFFEB);

    // Clear ten cycles into a divide aborts silently.
    @(negedge clk);
    opcode = 5'b01111; A = 32'hFFFFFFEF; B = 32'h00000005; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_busy", {63'h0, busy}, 64'h0);
    chk("clr_C", C, 64'h0);
    chk("clr_done", {63'h0, done}, 64'h0);
    ndone = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    chk("clr_no_done", 64'(ndone), 64'd0);
    run32(5'b00011, 32'h2, 32'h3, c, lat, bcyc, d, dn_after);
    chk("clr_add_C", c, 64'h5);
    chk("clr_add_latency", 64'(lat), 64'd1);

    // Back-to-back: new start accepted in the cycle done is high.
    @(negedge clk);
    opcode = 5'b00011; A = 32'd5; B = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    chk("b2b_first_done", {63'h0, done}, 64'h1);
    chk("b2b_first_C", C, 64'd11);
    opcode = 5'b01110; A = 32'd3; B = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_done_not_held", {63'h0, done}, 64'h0);
    chk("b2b_busy", {63'h0, busy}, 64'h1);
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_mul_latency", 64'(lat), 64'd34);
    chk("b2b_mul_C", C, 64'd12);

    // 8-bit instance: overflow corners.
    run8(5'b01110, 8'h80, 8'h80, c8, lat);
    chk("w8_mul_C", {48'h0, c8}, 64'h4000);
    chk("w8_mul_latency", 64'(lat), 64'd10);
    run8(5'b01111, 8'h80, 8'hFF, c8, lat);
    chk("w8_div_C", {48'h0, c8}, 64'h0080);
    chk("w8_div_latency", 64'(lat), 64'd10);
    chk("w8_div_dz", {63'h0, dz8}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised, registered successor to the datapath ALU.
- Single-cycle ops (add/sub/logic/shift/rotate/neg/not/immediate forms) complete in one clock.
- Signed multiply and signed divide run as iterative WIDTH-step sequences under a start/busy/done handshake.
- Sits between the A/B operand registers and the Z (HI/LO) register pair; the control unit issues start and stalls until done.

Parameters:
- WIDTH, 32, operand width; result C is 2*WIDTH; must be a power of two, 8 or larger.
- SHW, log2(WIDTH), number of B LSBs used as shift/rotate amount.

Ports:
- clk  input  1  rising-edge clock
- clear  input  1  synchronous active-high reset
- start  input  1  sampled only when busy=0; launches opcode on A, B
- opcode  input  5  operation select; same encoding as the CPU opcode field
- A  input  WIDTH  operand A (Ra / PC-relative base)
- B  input  WIDTH  operand B (Rb / immediate / shift amount)
- C  output  2*WIDTH  registered result; HI = C[2W-1:W], LO = C[W-1:0]
- busy  output  1  high while a multi-cycle op is in progress
- done  output  1  one-cycle pulse when C is updated
- div_by_zero  output  1  set with done on a divide with B=0; cleared on the next accepted start

Behaviour:
- Reset: sync on clk while clear=1; C=0, busy=0, done=0, div_by_zero=0, state=IDLE. Clear mid-operation aborts with no done pulse. Clear has priority over start.
- Opcodes:
  - 00011 add, 01011 addi, 00000 ld, 00001 ldi, 00010 st: LO=A+B mod 2^W.
  - 00100 sub: LO=A-B.
  - 01001 and, 01100 andi: LO=A&B.
  - 01010 or, 01101 ori: LO=A|B.
  - 10000 neg: LO=-B.
  - 10001 not: LO=~B.
  - 00101 shr: logical A>>B[SHW-1:0].
  - 00110 shl: A<<B[SHW-1:0].
  - 00111 ror, 01000 rol: rotate A by B[SHW-1:0].
  - For all of the above, HI=0.
  - 01110 mul: signed A*B, full 2W product in C.
  - 01111 div: signed, truncates toward zero; LO=quotient, HI=remainder; remainder sign = dividend sign.
  - 11001 nop, 11010 halt, 10010 br: C unchanged, done still pulses.
  - Any other opcode: C=0.
- FSM states: IDLE, ITER, FIX.
  - IDLE + start + single-cycle op: C written at that edge; done=1 the next cycle; stay IDLE.
  - IDLE + start + mul/div: latch |A|, |B| and result signs; load counter=WIDTH; busy=1; go to ITER.
  - ITER: one shift-add (mul) or restoring shift-subtract (div) step per clock; counter decrements; at counter 1 go to FIX.
  - FIX: apply two's-complement sign correction; write C; done=1 the next cycle; busy=0; return to IDLE.
  - Latency from the start-sampling edge to done high: 1 cycle for single-cycle ops, WIDTH+2 cycles for mul/div (34 at WIDTH=32).
- start while busy=1 is ignored: no queueing, operands not re-latched. A, B and opcode may change freely after acceptance.
- Back-to-back: start may be high in the same cycle done is high (busy=0). It is accepted, and done then pulses again per the latency rule.
- Divide by zero: no iteration; FIX reached next cycle; LO=all ones, HI=A; div_by_zero=1. Latency is 2.
- Overflow: mul of most-negative by most-negative gives the exact 2W result 2^(2W-2). div of most-negative by -1 gives LO=most-negative, HI=0 (wraps); no flag.
- C holds between operations. done is never high two cycles in a row for a single op.

Test Plan:
- Reset, then add: A=0x00000005, B=0xFFFFFFFE, start -> done next cycle, C=0x00000000_00000003, busy never 1.
- mul: A=0xFFFFFFFD (-3), B=7 -> busy 33 cycles, done at start+34, C=0xFFFFFFFF_FFFFFFEB.
- div: A=0xFFFFFFEF (-17), B=5 -> done at start+34, LO=0xFFFFFFFD, HI=0xFFFFFFFE, div_by_zero=0. Then A=9, B=0 -> done at start+2, LO=0xFFFFFFFF, HI=9, div_by_zero=1.
- rol: A=0x80000001, B=1 -> LO=0x00000003. ror: A=0x00000001, B=33 (amount 1) -> LO=0x80000000. shr: A=0x80000000, B=31 -> LO=1.
- mul started, second start with add at cycle +5 ignored -> single done at +34 with the mul result. clear at cycle +10 of a div -> busy=0, C=0, no done; fresh add works afterwards.
- WIDTH=8 instance: mul A=0x80, B=0x80 -> C=0x4000 at start+10. div A=0x80, B=0xFF -> LO=0x80, HI=0x00.
